// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-register stages: control bundle
// layout, occupancy state encoding and operand packing helper.
package pipe_pkg;

    localparam int CTRL_W = 9;

    localparam int WB_LSB = 7;
    localparam int WB_W   = 2;
    localparam int M_LSB  = 4;
    localparam int M_W    = 3;
    localparam int EX_LSB = 0;
    localparam int EX_W   = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    // Bit offset of packed element k when each element is w bits wide.
    function automatic int op_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/pipe_reg_skid_if.sv
// Valid/ready stage-boundary bundle: upstream beat, downstream beat, flush and
// the stall counter. master drives beats in and accepts them out; slave is the stage.
interface pipe_reg_skid_if #(
    parameter int DATA_W = 32,
    parameter int N_OPS  = 4,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int REG_W  = 5,
    parameter int N_REGS = 3,
    parameter int CNT_W  = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CTRL_W-1:0]         in_ctrl;
    logic [N_OPS*DATA_W-1:0]   in_ops;
    logic [N_REGS*REG_W-1:0]   in_regs;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [CTRL_W-1:0]         out_ctrl;
    logic [N_OPS*DATA_W-1:0]   out_ops;
    logic [N_REGS*REG_W-1:0]   out_regs;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        output in_valid, in_ctrl, in_ops, in_regs, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_ops, out_regs, stall_cnt
    );

    modport slave (
        input  in_valid, in_ctrl, in_ops, in_regs, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_ops, out_regs, stall_cnt
    );
endinterface

// File: rtl/pipe_slot.sv
// One payload slot (ctrl, operands, register indices) with load enable;
// clears to zero on reset.
module pipe_slot #(
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int OPS_W  = 128,
    parameter int REGS_W = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [OPS_W-1:0]  d_ops,
    input  logic [REGS_W-1:0] d_regs,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [OPS_W-1:0]  q_ops,
    output logic [REGS_W-1:0] q_regs
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_ctrl <= '0;
            q_ops  <= '0;
            q_regs <= '0;
        end else if (load) begin
            q_ctrl <= d_ctrl;
            q_ops  <= d_ops;
            q_regs <= d_regs;
        end
    end
endmodule

// File: rtl/pipe_reg_skid.sv
// Elastic pipeline register with two-entry skid buffer, flush, bubble ctrl
// gating and a saturating stall counter.
//
//   state | meaning
//   EMPTY | no beat held, outputs invalid
//   FULL  | main slot holds the beat on the outputs
//   SKID  | main and skid slots both hold beats, upstream stalled
module pipe_reg_skid #(
    parameter int DATA_W = 32,
    parameter int N_OPS  = 4,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int REG_W  = 5,
    parameter int N_REGS = 3,
    parameter int CNT_W  = 16
) (
    input  logic           clock,
    input  logic           reset,
    pipe_reg_skid_if.slave bus
);
    import pipe_pkg::*;

    localparam int OPS_W  = N_OPS * DATA_W;
    localparam int REGS_W = N_REGS * REG_W;

    pipe_state_t state_q, state_d;

    logic in_ready_q;
    logic out_valid;
    logic acc, take;
    logic load_main, load_skid, main_from_skid;

    logic [CTRL_W-1:0] main_ctrl,   skid_ctrl,   main_ctrl_d;
    logic [OPS_W-1:0]  main_ops,    skid_ops,    main_ops_d;
    logic [REGS_W-1:0] main_regs,   skid_regs,   main_regs_d;
    logic [CNT_W-1:0]  stall_q;

    assign out_valid = (state_q != EMPTY);
    assign acc       = bus.in_valid & in_ready_q;
    assign take      = out_valid & bus.out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    load_main = 1'b1;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (acc && take) begin
                    load_main = 1'b1;
                end else if (acc) begin
                    load_skid = 1'b1;
                    state_d   = SKID;
                end else if (take) begin
                    state_d   = EMPTY;
                end
            end
            SKID: begin
                if (take) begin
                    main_from_skid = 1'b1;
                    state_d        = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A flushed beat is dropped outright; slots keep their old payload.
        if (bus.flush) begin
            state_d        = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID);
        end
    end

    assign main_ctrl_d = main_from_skid ? skid_ctrl : bus.in_ctrl;
    assign main_regs_d = main_from_skid ? skid_regs : bus.in_regs;

    for (genvar k = 0; k < N_OPS; k++) begin : g_op_mux
        assign main_ops_d[op_lsb(k, DATA_W) +: DATA_W] = main_from_skid
            ? skid_ops[op_lsb(k, DATA_W) +: DATA_W]
            : bus.in_ops[op_lsb(k, DATA_W) +: DATA_W];
    end

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .OPS_W  (OPS_W),
        .REGS_W (REGS_W)
    ) u_main (
        .clock  (clock),
        .reset  (reset),
        .load   (load_main | main_from_skid),
        .d_ctrl (main_ctrl_d),
        .d_ops  (main_ops_d),
        .d_regs (main_regs_d),
        .q_ctrl (main_ctrl),
        .q_ops  (main_ops),
        .q_regs (main_regs)
    );

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .OPS_W  (OPS_W),
        .REGS_W (REGS_W)
    ) u_skid (
        .clock  (clock),
        .reset  (reset),
        .load   (load_skid),
        .d_ctrl (bus.in_ctrl),
        .d_ops  (bus.in_ops),
        .d_regs (bus.in_regs),
        .q_ctrl (skid_ctrl),
        .q_ops  (skid_ops),
        .q_regs (skid_regs)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Bubbles carry no control so no write/branch enable can leak downstream.
    assign bus.out_ctrl  = out_valid ? main_ctrl : '0;
    assign bus.out_ops   = main_ops;
    assign bus.out_regs  = main_regs;
    assign bus.out_valid = out_valid;
    assign bus.in_ready  = in_ready_q;
    assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid built wide (6 x 64-bit operands) with a
// 4-bit stall counter so saturation is reachable quickly.
module tb_pipe_reg_skid;
    localparam int DW   = 64;
    localparam int NO   = 6;
    localparam int CW   = 9;
    localparam int RW   = 5;
    localparam int NR   = 3;
    localparam int CNTW = 4;
    localparam int OW   = NO * DW;
    localparam int RGW  = NR * RW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_pass   = 0;
    int   n_checks = 0;

    pipe_reg_skid_if #(
        .DATA_W(DW), .N_OPS(NO), .CTRL_W(CW), .REG_W(RW), .N_REGS(NR), .CNT_W(CNTW)
    ) bus ();

    pipe_reg_skid #(
        .DATA_W(DW), .N_OPS(NO), .CTRL_W(CW), .REG_W(RW), .N_REGS(NR), .CNT_W(CNTW)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [OW-1:0] mk_ops(input logic [7:0] tag);
        logic [OW-1:0] o;
        for (int k = 0; k < NO; k++) o[k*DW +: DW] = {48'h0, tag, 8'(k)};
        return o;
    endfunction

    function automatic logic [RGW-1:0] mk_regs(input logic [4:0] t);
        return {t + 5'd2, t + 5'd1, t};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [7:0] tag);
        bus.in_valid = v;
        bus.in_ctrl  = c;
        bus.in_ops   = mk_ops(tag);
        bus.in_regs  = mk_regs(tag[4:0]);
    endtask

    task automatic chk_beat(input string tag, input logic [CW-1:0] c, input logic [7:0] t);
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_ctrl"},  bus.out_ctrl, c);
        chk({tag, "_ops"},   bus.out_ops, mk_ops(t));
        chk({tag, "_regs"},  bus.out_regs, mk_regs(t[4:0]));
    endtask

    initial begin
        logic [CW-1:0]  w_ctrl;
        logic [OW-1:0]  w_ops;
        logic [RGW-1:0] w_regs;

        bus.in_valid  = 1'b0;
        bus.in_ctrl   = '0;
        bus.in_ops    = '0;
        bus.in_regs   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_ctrl",  bus.out_ctrl, '0);
        chk("rst_out_ops",   bus.out_ops, '0);
        chk("rst_out_regs",  bus.out_regs, '0);
        chk("rst_in_ready",  bus.in_ready, 1'b1);
        chk("rst_stall",     bus.stall_cnt, '0);
        reset = 1'b0;

        // Streaming with out_ready high
        bus.in_valid      = 1'b1;
        bus.in_ctrl       = 9'h1A5;
        bus.in_ops        = '0;
        bus.in_ops[63:0]  = 64'h0000_0040;
        bus.in_regs       = {5'd1, 5'd2, 5'd3};
        bus.out_ready     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s1_valid",    bus.out_valid, 1'b1);
            chk("s1_ctrl",     bus.out_ctrl, 9'h1A5);
            chk("s1_op0",      bus.out_ops[63:0], 64'h40);
            chk("s1_regs",     bus.out_regs, {5'd1, 5'd2, 5'd3});
            chk("s1_in_ready", bus.in_ready, 1'b1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("s1_bubble_valid", bus.out_valid, 1'b0);
        chk("s1_bubble_ctrl",  bus.out_ctrl, '0);
        chk("s1_bubble_hold",  bus.out_ops[63:0], 64'h40);
        chk("s1_stall",        bus.stall_cnt, '0);

        // Back-pressure through the skid slot: A, B, C
        drive(1'b1, 9'h0A1, 8'h01);
        tick();
        chk_beat("bp_A0", 9'h0A1, 8'h01);
        bus.out_ready = 1'b0;
        drive(1'b1, 9'h0B2, 8'h02);
        tick();
        chk_beat("bp_A1", 9'h0A1, 8'h01);
        chk("bp_in_ready_low", bus.in_ready, 1'b0);
        chk("bp_stall1", bus.stall_cnt, 4'd1);
        drive(1'b1, 9'h0C3, 8'h03);
        tick();
        chk_beat("bp_A2", 9'h0A1, 8'h01);
        chk("bp_in_ready_low2", bus.in_ready, 1'b0);
        chk("bp_stall2", bus.stall_cnt, 4'd2);
        bus.out_ready = 1'b1;
        tick();
        chk_beat("bp_B", 9'h0B2, 8'h02);
        chk("bp_in_ready_back", bus.in_ready, 1'b1);
        tick();
        chk_beat("bp_C", 9'h0C3, 8'h03);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_drain_valid", bus.out_valid, 1'b0);
        chk("bp_stall_hold", bus.stall_cnt, 4'd2);

        // Flush while in SKID with a beat offered
        bus.out_ready = 1'b0;
        drive(1'b1, 9'h0D4, 8'h04);
        tick();
        chk_beat("fl_D", 9'h0D4, 8'h04);
        drive(1'b1, 9'h0E5, 8'h05);
        tick();
        chk("fl_in_ready_low", bus.in_ready, 1'b0);
        chk("fl_stall3", bus.stall_cnt, 4'd3);
        drive(1'b1, 9'h0F6, 8'h06);
        bus.flush = 1'b1;
        tick();
        chk("fl_valid", bus.out_valid, 1'b0);
        chk("fl_ctrl",  bus.out_ctrl, '0);
        chk("fl_in_ready", bus.in_ready, 1'b1);
        chk("fl_stall4", bus.stall_cnt, 4'd4);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("fl_no_resurrect", bus.out_valid, 1'b0);
        // Flush in the accept cycle discards the incoming beat
        drive(1'b1, 9'h1C7, 8'h07);
        bus.flush = 1'b1;
        tick();
        chk("fla_valid", bus.out_valid, 1'b0);
        chk("fla_ops_hold", bus.out_ops, mk_ops(8'h04));
        chk("fla_in_ready", bus.in_ready, 1'b1);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;

        // Asynchronous reset between edges
        drive(1'b1, 9'h188, 8'h08);
        tick();
        chk_beat("ar_H", 9'h188, 8'h08);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", bus.out_valid, 1'b0);
        chk("ar_ctrl",  bus.out_ctrl, '0);
        chk("ar_ops",   bus.out_ops, '0);
        chk("ar_regs",  bus.out_regs, '0);
        chk("ar_in_ready", bus.in_ready, 1'b1);
        chk("ar_stall", bus.stall_cnt, '0);
        #1 reset = 1'b0;
        drive(1'b1, 9'h099, 8'h09);
        tick();
        chk_beat("ar_I", 9'h099, 8'h09);

        // Stall counter saturation
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", bus.stall_cnt, 4'd14);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_15", bus.stall_cnt, 4'd15);
        chk_beat("sat_I_held", 9'h099, 8'h09);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("sat_flush_valid", bus.out_valid, 1'b0);
        chk("sat_after_flush", bus.stall_cnt, 4'd15);
        tick();
        chk("sat_idle", bus.stall_cnt, 4'd15);

        // Walking ones on every operand, reg index and ctrl, back to back
        bus.out_ready = 1'b1;
        for (int b = 0; b < DW; b++) begin
            w_ctrl = CW'(1) << (b % CW);
            for (int k = 0; k < NO; k++) w_ops[k*DW +: DW] = DW'(1) << ((b + k) % DW);
            for (int r = 0; r < NR; r++) w_regs[r*RW +: RW] = RW'(1) << ((b + r) % RW);
            bus.in_valid = 1'b1;
            bus.in_ctrl  = w_ctrl;
            bus.in_ops   = w_ops;
            bus.in_regs  = w_regs;
            tick();
            chk("walk_valid", bus.out_valid, 1'b1);
            chk("walk_ctrl",  bus.out_ctrl, w_ctrl);
            chk("walk_ops",   bus.out_ops, w_ops);
            chk("walk_regs",  bus.out_regs, w_regs);
            chk("walk_in_ready", bus.in_ready, 1'b1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("walk_end_valid", bus.out_valid, 1'b0);
        chk("walk_end_ctrl",  bus.out_ctrl, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_reg_skid.md
# pipe_reg_skid

Parametrised, elastic pipeline register for the stage boundaries of the RISC-V core, starting with ID/EX. It carries a control bundle, N data operands and N register indices between stages under a valid/ready handshake. A two-entry skid buffer keeps `in_ready` fully registered. It also provides synchronous flush for bubble insertion and a saturating stall-cycle counter.

## Interface
Parameters:
- `DATA_W`, default 32: width of each data operand (npc, rs1/rs2 data, immediate).
- `N_OPS`, default 4: number of data operands carried.
- `CTRL_W`, default 9: control bundle width, laid out as WB[8:7], M[6:4], EX[3:0].
- `REG_W`, default 5: register-index width.
- `N_REGS`, default 3: number of register indices carried (rs1, rs2, rd).
- `CNT_W`, default 16: stall-counter width.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  stage can accept; registered.
- `in_ctrl`  in  CTRL_W  control bundle.
- `in_ops`  in  N_OPS*DATA_W  operands, operand k at [k*DATA_W +: DATA_W].
- `in_regs`  in  N_REGS*REG_W  register indices, same packing.
- `flush`  in  1  synchronous kill of all held and incoming beats.
- `out_valid`  out  1  downstream beat valid.
- `out_ready`  in  1  downstream accepts.
- `out_ctrl`  out  CTRL_W  control; forced 0 whenever `out_valid`=0.
- `out_ops`  out  N_OPS*DATA_W  operands.
- `out_regs`  out  N_REGS*REG_W  register indices.
- `stall_cnt`  out  CNT_W  count of cycles with `out_valid` & !`out_ready`; saturating.

## Operation
- `acc` = `in_valid` & `in_ready`. `take` = `out_valid` & `out_ready`.
- Storage is a main slot, which drives the outputs, and a skid slot. Each slot holds a ctrl, ops and regs payload.
- States:
  - EMPTY: no beat held.
  - FULL: main slot valid.
  - SKID: both slots valid.
- Transitions from EMPTY:
  - acc: load main, go to FULL.
- Transitions from FULL:
  - acc & take: reload main, stay in FULL.
  - acc & !take: load skid, go to SKID.
  - !acc & take: go to EMPTY.
  - otherwise: hold.
- Transitions from SKID:
  - `in_ready`=0.
  - take: main ← skid, go to FULL.
  - otherwise: hold.
- `in_ready` is registered and equals "next state ≠ SKID". It has no combinational path from `out_ready`.
- Flush:
  - `flush`=1 forces next state to EMPTY from any state.
  - An incoming beat accepted in the same cycle is discarded.
  - `in_ready` is 1 the following cycle.
  - Flush has priority over take; the downstream take in that cycle still completes.
- Bubble rule:
  - `out_ctrl` is 0 whenever `out_valid`=0, so no RegWrite/MemWrite/Branch can leak.
  - `out_ops` and `out_regs` hold their last value when invalid.
- `stall_cnt` increments when `out_valid` & !`out_ready`. It saturates at 2^CNT_W−1 and does not wrap. Flush does not clear it; reset does.

## Timing
- Reset values, asynchronous and immediate:
  - State EMPTY.
  - `out_valid`=0, `out_ctrl`=0, `out_ops`=0, `out_regs`=0.
  - Skid slot 0.
  - `in_ready`=1.
  - `stall_cnt`=0.
- Latency: a beat accepted at edge n appears on the outputs after edge n, i.e. 1 cycle.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Back-pressure:
  - The first cycle of `out_ready`=0 absorbs at most one extra beat into the skid slot.
  - `in_ready` falls after that same edge.
- Reset asserted mid-operation discards both slots. The first beat is accepted at the first edge after reset deassertion.
- Ordering is strictly FIFO; no beat is duplicated or dropped except by flush.

## Structure
- Shared package `pipe_pkg` holds:
  - CTRL_W and the WB/M/EX field offsets and widths.
  - The state enum {EMPTY, FULL, SKID}.
  - A helper for the operand slice offset.
- Sub-module `pipe_slot`: payload register with load enable and async reset to 0, instantiated twice (main, skid).
- The top level holds the FSM, `in_ready`, ctrl gating and the stall counter.

## Test plan
- Reset, then in_valid=1, ctrl=9'h1A5, op0=32'h0000_0040, out_ready=1 for 4 cycles -> out_valid after 1 cycle, values match in order, in_ready stays 1.
- Beats A, B, C presented, out_ready=0 from the cycle A is output -> B captured in skid, in_ready=0, C held upstream; raise out_ready -> A, B, C delivered in order with no loss.
- Flush while in SKID with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; the flushed beats never appear.
- Assert reset asynchronously mid-stream between edges -> all outputs 0 immediately; first post-reset beat appears 1 cycle after acceptance.
- CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds; flush leaves it at 15.
- N_OPS=6, DATA_W=64 build: walking-ones pattern on every operand and reg index -> bit-exact output for each beat.
